word_reader: RTL and testbench

Reader-side companion to the step controller's enabled 64-bit register. It captures a 64-bit word whenever the controller pulses `en`, then delivers it downstream one byte at a time, LSB byte first, over a valid/ready handshake. It reports a sticky overrun when a load pulse arrives while a word is still draining, and it counts completed words.

---
 rtl/word_reader.sv | 99 +++++++++
 tb/tb_word_reader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/word_reader.sv
// Captures a WIDTH-bit word on each accepted load strobe and drains it
// downstream one BYTE lane per handshake, least-significant lane first.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | nothing held; next strobe is captured
// SEND  | word held; lane lane_q offered on byte_data
module word_reader #(
    parameter int WIDTH = 64,
    parameter int BYTE  = 8,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic             load_ok,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic [BYTE-1:0]  byte_data,
    output logic             byte_last,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic [CNTW-1:0]  words_done
);

    localparam int LANES = WIDTH / BYTE;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] word_q;
    logic [LW-1:0]    lane_q;

    logic [BYTE-1:0]  lane_data [LANES];
    logic             sending;
    logic             lane_is_last;
    logic             fire;
    logic             fin;
    logic             capture;
    logic             drop;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_data[g] = word_q[g*BYTE +: BYTE];
    end

    assign sending      = (state_q == SEND);
    assign lane_is_last = (lane_q == LW'(LANES - 1));
    assign fire         = sending & byte_ready;
    assign fin          = fire & lane_is_last;

    // load_ok deliberately excludes en so upstream can gate its strobe on it.
    assign load_ok      = ~sending | fin;
    assign capture      = en & load_ok;
    assign drop         = en & ~load_ok;

    assign byte_valid   = sending;
    assign busy         = sending;
    assign byte_last    = sending & lane_is_last;
    assign byte_data    = sending ? lane_data[lane_q] : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            word_q     <= '0;
            lane_q     <= '0;
            words_done <= '0;
            overrun    <= 1'b0;
        end else begin
            if (fin) begin
                words_done <= words_done + CNTW'(1);
            end

            // A strobe coinciding with the final lane reloads with no bubble.
            if (capture) begin
                word_q  <= d;
                lane_q  <= '0;
                state_q <= SEND;
            end else if (fin) begin
                lane_q  <= '0;
                state_q <= IDLE;
            end else if (fire) begin
                lane_q  <= lane_q + LW'(1);
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_word_reader.sv
// Randomised plus directed bench for word_reader: stimulus pushes expected
// lanes into a scoreboard, a monitor pops and compares on each handshake.
module tb_word_reader;

    localparam int WIDTH = 64;
    localparam int BYTE  = 8;
    localparam int CNTW  = 4;
    localparam int LANES = WIDTH / BYTE;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [WIDTH-1:0] d;
    logic             load_ok;
    logic             byte_valid;
    logic             byte_ready;
    logic [BYTE-1:0]  byte_data;
    logic             byte_last;
    logic             busy;
    logic             overrun;
    logic             clr_overrun;
    logic [CNTW-1:0]  words_done;

    always #5 clk = ~clk;

    word_reader #(.WIDTH(WIDTH), .BYTE(BYTE), .CNTW(CNTW)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .d          (d),
        .load_ok    (load_ok),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .busy       (busy),
        .overrun    (overrun),
        .clr_overrun(clr_overrun),
        .words_done (words_done)
    );

    typedef struct {
        logic [BYTE-1:0] b;
        logic            last;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   m_left = 0;
    int   m_cnt  = 0;
    bit   m_ovr  = 1'b0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word is a list of pending lanes; the model only tracks how
    // many lanes are still owed and the bookkeeping counters.
    task automatic cyc(input bit e, input logic [WIDTH-1:0] dd, input bit r,
                       input bit rst, input bit c);
        bit fire;
        bit fin;
        bit lok;
        @(negedge clk);
        en = e; d = dd; byte_ready = r; reset = rst; clr_overrun = c;
        #4;
        if (!rst) begin
            m_left = 0;
            m_cnt  = 0;
            m_ovr  = 1'b0;
            sb.delete();
        end else begin
            fire = (m_left > 0) && r;
            fin  = fire && (m_left == 1);
            lok  = (m_left == 0) || fin;
            if (fire) m_left--;
            if (fin)  m_cnt = (m_cnt + 1) % (1 << CNTW);
            if (e && lok) begin
                for (int i = 0; i < LANES; i++)
                    sb.push_back('{dd[BYTE*i +: BYTE], (i == LANES - 1)});
                m_left = LANES;
            end
            if (e && !lok)  m_ovr = 1'b1;
            else if (c)     m_ovr = 1'b0;
        end
    endtask

    logic [BYTE-1:0] prev_data;
    logic            prev_last;
    bit              prev_stall = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                chk("byte_valid", byte_valid, m_left > 0);
                chk("busy", busy, m_left > 0);
                chk("load_ok", load_ok, (m_left == 0) || (byte_ready && m_left == 1));
                chk("overrun", overrun, m_ovr);
                chk("words_done", words_done, m_cnt);
                if (m_left == 0) begin
                    chk("idle_data", byte_data, 0);
                    chk("idle_last", byte_last, 0);
                end
                if (prev_stall) begin
                    chk("stall_data", byte_data, prev_data);
                    chk("stall_last", byte_last, prev_last);
                end
                if (byte_valid) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_lane: got %0h expected no lane at %0t",
                                 byte_data, $time);
                    end else begin
                        chk("byte_data", byte_data, sb[0].b);
                        chk("byte_last", byte_last, sb[0].last);
                        if (byte_ready && reset) void'(sb.pop_front());
                    end
                end
                prev_stall = byte_valid && !byte_ready && reset;
                prev_data  = byte_data;
                prev_last  = byte_last;
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] w;
        en = 1'b0; d = '0; byte_ready = 1'b0; reset = 1'b0; clr_overrun = 1'b0;
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 0, 0);
        mon_en = 1'b1;

        // single word, ready held high
        w = 64'h8877_6655_4433_2211;
        cyc(1, w, 1, 1, 0);
        repeat (10) cyc(0, '0, 1, 1, 0);

        // same word with stalls
        cyc(1, w, 1, 1, 0);
        for (int i = 0; i < 24; i++) cyc(0, '0, (i % 3) == 0, 1, 0);
        repeat (4) cyc(0, '0, 1, 1, 0);

        // controller pattern: two strobes on, one off
        for (int i = 0; i < 30; i++) cyc((i % 3) != 2, {$urandom, $urandom}, 1, 1, 0);
        cyc(0, '0, 1, 1, 1);
        repeat (10) cyc(0, '0, 1, 1, 0);

        // back-to-back words, strobe lands on the final lane; wraps the counter
        for (int k = 0; k < 20; k++) begin
            cyc(1, {$urandom, $urandom}, 1, 1, 0);
            repeat (LANES - 1) cyc(0, '0, 1, 1, 0);
        end
        repeat (3) cyc(0, '0, 1, 1, 0);

        // reset while lane 3 is offered, with overrun set
        cyc(1, {$urandom, $urandom}, 1, 1, 0);
        cyc(1, {$urandom, $urandom}, 1, 1, 0);
        cyc(0, '0, 1, 1, 0);
        cyc(0, '0, 1, 1, 0);
        cyc(0, '0, 1, 0, 0);
        repeat (6) cyc(0, '0, 1, 1, 0);

        // clear coinciding with a dropped strobe: set wins
        cyc(1, {$urandom, $urandom}, 0, 1, 0);
        cyc(1, {$urandom, $urandom}, 0, 1, 1);
        cyc(0, '0, 0, 1, 1);
        repeat (10) cyc(0, '0, 1, 1, 0);

        repeat (3000) cyc($urandom_range(0, 3) == 0, {$urandom, $urandom},
                          $urandom_range(0, 2) != 0, $urandom_range(0, 199) != 0,
                          $urandom_range(0, 15) == 0);
        repeat (12) cyc(0, '0, 1, 1, 0);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
